// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - parametrised N-bit Gray-code counter with load, saturate and wrap flag
module gray_counter_n #(
    parameter int WIDTH = 4,
    parameter int SATURATE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap,
    output logic             at_limit
);

    localparam bit SAT = (SATURATE != 0);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_B = '1;
    localparam logic [WIDTH-1:0] MAX_G = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] b_step;
    logic [WIDTH-1:0] gray_nxt;
    logic [WIDTH-1:0] limit_val;
    logic             at_end;
    logic             wrap_nxt;
    logic             acc;

    // Running XOR from the MSB down converts Gray to binary.
    always_comb begin
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

    always_comb begin
        at_end    = up ? (bin == MAX_B) : (bin == '0);
        b_step    = up ? (bin + ONE) : (bin - ONE);
        limit_val = up ? MAX_G : '0;
        gray_nxt  = gray;
        wrap_nxt  = 1'b0;
        if (load) begin
            gray_nxt = load_val;
        end else if (en) begin
            if (!(at_end && SAT)) begin
                gray_nxt = b_step ^ (b_step >> 1);
                wrap_nxt = at_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gray     <= RESET_VAL;
            wrap     <= 1'b0;
            at_limit <= (RESET_VAL == limit_val);
        end else begin
            gray     <= gray_nxt;
            wrap     <= wrap_nxt;
            at_limit <= (gray_nxt == limit_val);
        end
    end

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - scoreboard bench for gray_counter_n across widths and modes
module tb_gray_counter_n;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    logic [3:0]  a_g, a_b, s_g, s_b, r_g, r_b;
    logic [1:0]  w2_g, w2_b;
    logic [7:0]  w8_g, w8_b;
    logic [15:0] w16_g, w16_b;
    logic        a_w, a_l, s_w, s_l, r_w, r_l, w2_w, w2_l, w8_w, w8_l, w16_w, w16_l;

    int tests = 0;
    int failed = 0;

    typedef struct {
        int          id;
        logic [15:0] g;
        logic [15:0] b;
        logic        w;
        logic        cl;
        logic        lim;
        logic        hc;
        string       nm;
    } exp_t;
    exp_t q[$];

    logic [3:0] seq [16];

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'b0000)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .gray(a_g), .bin(a_b), .wrap(a_w), .at_limit(a_l));
    gray_counter_n #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'b0000)) u_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .gray(s_g), .bin(s_b), .wrap(s_w), .at_limit(s_l));
    gray_counter_n #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'b0110)) u_r (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .gray(r_g), .bin(r_b), .wrap(r_w), .at_limit(r_l));
    gray_counter_n #(.WIDTH(2), .SATURATE(0), .RESET_VAL(2'b00)) u_w2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[1:0]),
        .gray(w2_g), .bin(w2_b), .wrap(w2_w), .at_limit(w2_l));
    gray_counter_n #(.WIDTH(8), .SATURATE(0), .RESET_VAL(8'h00)) u_w8 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
        .gray(w8_g), .bin(w8_b), .wrap(w8_w), .at_limit(w8_l));
    gray_counter_n #(.WIDTH(16), .SATURATE(0), .RESET_VAL(16'h0000)) u_w16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray(w16_g), .bin(w16_b), .wrap(w16_w), .at_limit(w16_l));

    function automatic logic [15:0] g_of(input int b);
        logic [15:0] v;
        v = b[15:0];
        return v ^ (v >> 1);
    endfunction

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [15:0] lv);
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int id, input logic [15:0] g, input logic [15:0] b, input logic w,
                       input logic cl, input logic lim, input logic hc, input string nm);
        exp_t e;
        e.id = id; e.g = g; e.b = b; e.w = w; e.cl = cl; e.lim = lim; e.hc = hc; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic sweep(input int id, input int w, input int start, input int n);
        int mask;
        int b;
        int nb;
        mask = (1 << w) - 1;
        b = start;
        drive(1, 0, 1, 1, g_of(start));
        chk(id, g_of(start), start[15:0], 0, 0, 0, 0, "sweep_load");
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 1, 0, 16'h0);
            nb = (b + 1) & mask;
            chk(id, g_of(nb), nb[15:0], (b == mask), 0, 0, 1, "sweep_step");
            b = nb;
        end
    endtask

    // Monitor: outputs are registered, so every queued expectation is checked on the falling edge.
    logic [15:0] prev [6];
    initial begin
        exp_t        e;
        logic [15:0] ag, ab;
        logic        aw, al;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.id)
                    0: begin ag = 16'(a_g);  ab = 16'(a_b);  aw = a_w;   al = a_l;   end
                    1: begin ag = 16'(s_g);  ab = 16'(s_b);  aw = s_w;   al = s_l;   end
                    2: begin ag = 16'(r_g);  ab = 16'(r_b);  aw = r_w;   al = r_l;   end
                    3: begin ag = 16'(w2_g); ab = 16'(w2_b); aw = w2_w;  al = w2_l;  end
                    4: begin ag = 16'(w8_g); ab = 16'(w8_b); aw = w8_w;  al = w8_l;  end
                    default: begin ag = w16_g; ab = w16_b; aw = w16_w; al = w16_l; end
                endcase
                tests++;
                if (ag !== e.g) begin
                    failed++;
                    $display("FAIL %s.gray id=%0d got %h want %h", e.nm, e.id, ag, e.g);
                end
                tests++;
                if (ab !== e.b) begin
                    failed++;
                    $display("FAIL %s.bin id=%0d got %h want %h", e.nm, e.id, ab, e.b);
                end
                tests++;
                if (aw !== e.w) begin
                    failed++;
                    $display("FAIL %s.wrap id=%0d got %b want %b", e.nm, e.id, aw, e.w);
                end
                if (e.cl) begin
                    tests++;
                    if (al !== e.lim) begin
                        failed++;
                        $display("FAIL %s.at_limit id=%0d got %b want %b", e.nm, e.id, al, e.lim);
                    end
                end
                if (e.hc) begin
                    tests++;
                    if ($countones(ag ^ prev[e.id]) != 1) begin
                        failed++;
                        $display("FAIL %s.onebit id=%0d got %h prev %h want distance 1",
                                 e.nm, e.id, ag, prev[e.id]);
                    end
                end
                prev[e.id] = ag;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        // Reset state
        drive(0, 0, 1, 0, 16'h0);
        drive(0, 1, 1, 1, 16'hffff);
        chk(0, 16'h0, 16'h0, 0, 1, 0, 0, "reset_a");
        chk(1, 16'h0, 16'h0, 0, 1, 0, 0, "reset_s");
        chk(2, 16'h6, 16'h4, 0, 0, 0, 0, "reset_r");

        // Full up cycle with wrap
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 1, 0, 16'h0);
            chk(0, 16'(seq[i]), 16'((i + 1) % 16), (i == 15), 1, (seq[i] == 4'b1000), 1, "up_seq");
        end
        drive(1, 0, 1, 0, 16'h0);
        chk(0, 16'h0, 16'h0, 0, 1, 0, 0, "wrap_clear");

        // Down-wrap
        drive(0, 0, 0, 0, 16'h0);
        chk(0, 16'h0, 16'h0, 0, 0, 0, 0, "reset2");
        drive(1, 1, 0, 0, 16'h0);
        chk(0, 16'h8, 16'hf, 1, 1, 0, 1, "down_wrap");
        drive(1, 1, 0, 0, 16'h0);
        chk(0, 16'h9, 16'he, 0, 1, 0, 1, "down_next");

        // Load, count after load, load beats enable
        drive(1, 0, 1, 1, 16'h000a);
        chk(0, 16'ha, 16'hc, 0, 0, 0, 0, "load");
        drive(1, 1, 1, 0, 16'h0);
        chk(0, 16'hb, 16'hd, 0, 0, 0, 1, "load_count");
        drive(1, 1, 1, 1, 16'h0003);
        chk(0, 16'h3, 16'h2, 0, 0, 0, 0, "load_wins");

        // Saturate instance: climb to max, hold, then step down
        drive(0, 0, 1, 0, 16'h0);
        chk(1, 16'h0, 16'h0, 0, 1, 0, 0, "sat_reset");
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 1, 0, 16'h0);
            chk(1, 16'(seq[i]), 16'(i + 1), 0, 1, (i == 14), 1, "sat_up");
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 16'h0);
            chk(1, 16'h8, 16'hf, 0, 1, 1, 0, "sat_hold");
        end
        drive(1, 1, 0, 0, 16'h0);
        chk(1, 16'h9, 16'he, 0, 1, 0, 1, "sat_down");
        drive(0, 0, 0, 0, 16'h0);
        drive(1, 1, 0, 0, 16'h0);
        chk(1, 16'h0, 16'h0, 0, 1, 1, 0, "sat_low_hold");

        // Reset mid-count with non-zero reset value
        drive(0, 0, 1, 0, 16'h0);
        chk(2, 16'h6, 16'h4, 0, 0, 0, 0, "rv_reset");
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 16'h0);
            chk(2, 16'(seq[i + 4]), 16'(i + 5), 0, 0, 0, 1, "rv_count");
        end
        drive(0, 1, 1, 1, 16'h0);
        chk(2, 16'h6, 16'h4, 0, 0, 0, 0, "rv_midreset");
        drive(1, 1, 1, 0, 16'h0);
        chk(2, 16'h7, 16'h5, 0, 0, 0, 1, "rv_resume");

        // Width sweep
        sweep(3, 2, 0, 4);
        sweep(4, 8, 0, 256);
        sweep(5, 16, 0, 48);
        sweep(5, 16, 65536 - 40, 64);
        for (int k = 0; k < 3; k++) sweep(5, 16, int'($urandom_range(0, 65535)), 64);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised N-bit Gray-code counter. It is the successor to the fixed 4-bit Gray counter in the synchronous-circuit library.
- The count state is held internally, so the caller does not feed the current state back in.
- Adds up/down counting, count enable, synchronous load, wrap or saturate mode, terminal-event flagging and a binary-equivalent output.
- Used as a standalone counter and as a pointer source for clock-domain-safe structures; the output changes at most one bit per clock.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- SATURATE, 0, 0 = wrap around at the ends; 1 = hold at the ends.
- RESET_VAL, 0, Gray-coded value loaded on reset. Must be a WIDTH-bit value.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement (in Gray sequence order).
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  Gray-coded value to load.
- gray  output  WIDTH  registered Gray-code count.
- bin  output  WIDTH  binary equivalent of gray; combinational from the gray register.
- wrap  output  1  registered one-cycle pulse: the previous clock wrapped the count (max to 0 or 0 to max).
- at_limit  output  1  registered level: count equals the end value in the current direction (max if up=1, 0 if up=0). Evaluated from the current gray and the current up input.

Behaviour:
- Reset: reset is synchronous and active-low. On a clk rising edge with reset=0: gray <= RESET_VAL, wrap <= 0. While reset=0, en and load are ignored.
- Priority on each rising edge with reset=1: load > en > hold.
- Load: load=1 gives gray <= load_val and wrap <= 0, regardless of en and up. Any bit pattern is accepted; there is no single-bit-change guarantee across a load.
- Count: en=1, load=0.
  - Compute b = Gray-to-binary(gray).
  - b_next = b+1 if up=1, b-1 if up=0, modulo 2^WIDTH.
  - gray <= b_next ^ (b_next >> 1).
  - Exactly one bit of gray changes per count step. This is a required invariant.
- Ends of the range: max = binary 2^WIDTH-1, which is Gray 1 followed by WIDTH-1 zeros; min = 0.
  - SATURATE=0: up at max goes to 0; down at 0 goes to max. wrap <= 1 for exactly the next cycle, otherwise wrap <= 0.
  - SATURATE=1: up at max and down at 0 hold the value; wrap is always 0.
- Hold: en=0, load=0 gives gray unchanged and wrap <= 0.
- bin: pure combinational XOR-prefix of gray, MSB first: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i].
- Latency: gray updates on the edge where en or load is sampled. bin follows in the same cycle.
- Reset mid-count: takes effect on that edge and overrides load and en. wrap is cleared.
- A direction change mid-sequence is legal and takes effect on the same edge.
- No X propagation: gray must never be X after the first reset edge.

Test Plan:
- Reset, then en=1, up=1, WIDTH=4, SATURATE=0 for 17 clocks:
  - gray = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap pulses only in the cycle after 1000 -> 0000.
  - The bench checks one-bit Hamming distance on every step.
- Down-wrap: from reset (0000) with up=0, en=1 -> gray = 1000, bin = 1111, wrap = 1 for one cycle. Next step gives 1001, wrap = 0.
- Load: load=1, load_val=1010 (bin 12) -> gray = 1010, bin = 1100. Then en=1, up=1 -> 1011 (bin 13). Assert load and en together -> load wins.
- Saturate (SATURATE=1): count up to 1000 and hold 3 extra clocks -> gray stays 1000, at_limit = 1, wrap never asserts. up=0 -> 1001.
- Reset mid-operation with RESET_VAL=0110: drive reset=0 while en=1 at gray=1101 -> next edge gray = 0110, wrap = 0, load ignored. Release reset -> counting resumes at 0111.
- Parameter sweep over WIDTH=2, 8, 16: full up cycle (2^WIDTH steps; 16 uses random windows plus the ends) -> bin = cycle index mod 2^WIDTH and one-bit change on each step.
